// File: rtl/mem_sram_ctrl.sv
// Memory-stage controller: turns one 32-bit LDR/STR into two 16-bit
// external SRAM accesses (low halfword, then high halfword) and holds the
// pipeline frozen through ready until the word is complete.
module mem_sram_ctrl #(
  parameter logic [31:0] BASE_ADDR     = 32'd1024,
  parameter int          SRAM_AW       = 18,
  parameter int          ACCESS_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  inout  wire  [15:0]        SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_WE_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_CE_N,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N
);

  // Phase counter must hold ACCESS_CYCLES-1; keep it at least one bit wide.
  localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic               op;        // 1 = write
  logic [SRAM_AW-2:0] idx;
  logic [31:0]        wdata;
  logic [SRAM_AW-2:0] nidx;
  logic               dq_oe;
  logic [15:0]        dq_out;

  // Word index relative to the data-memory base; wraps modulo 2^32, no range check.
  assign nidx = (SRAM_AW-1)'((address - BASE_ADDR) >> 2);

  // Freeze starts in the same cycle the request shows up.
  assign ready = (state == DONE) | ((state == IDLE) & ~rd_en & ~wr_en);

  // Bus is driven only while a write phase is active (OE_N is high then).
  assign SRAM_DQ = dq_oe ? dq_out : 16'bz;

  // Sequencer: state, latched request, registered SRAM controls and load data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      op        <= 1'b0;
      idx       <= '0;
      wdata     <= '0;
      read_data <= '0;
      SRAM_ADDR <= '0;
      SRAM_WE_N <= 1'b1;
      SRAM_OE_N <= 1'b1;
      SRAM_CE_N <= 1'b1;
      SRAM_UB_N <= 1'b1;
      SRAM_LB_N <= 1'b1;
      dq_oe     <= 1'b0;
      dq_out    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rd_en | wr_en) begin
            state     <= LO;
            cnt       <= CNT_INIT;
            op        <= wr_en;
            idx       <= nidx;
            wdata     <= write_data;
            SRAM_ADDR <= {nidx, 1'b0};
            SRAM_CE_N <= 1'b0;
            SRAM_UB_N <= 1'b0;
            SRAM_LB_N <= 1'b0;
            SRAM_WE_N <= ~wr_en;
            SRAM_OE_N <= wr_en;
            dq_oe     <= wr_en;
            dq_out    <= write_data[15:0];
          end
        end
        LO: begin
          if (cnt == '0) begin
            if (!op) read_data[15:0] <= SRAM_DQ;
            state     <= HI;
            cnt       <= CNT_INIT;
            SRAM_ADDR <= {idx, 1'b1};
            dq_out    <= wdata[31:16];
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HI: begin
          if (cnt == '0) begin
            if (!op) read_data[31:16] <= SRAM_DQ;
            state     <= DONE;
            SRAM_WE_N <= 1'b1;
            SRAM_OE_N <= 1'b1;
            SRAM_CE_N <= 1'b1;
            SRAM_UB_N <= 1'b1;
            SRAM_LB_N <= 1'b1;
            dq_oe     <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;   // DONE
      endcase
    end
  end

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Directed bench for mem_sram_ctrl: one instance with N=1 for function,
// reset and random traffic, one with N=3 for latency scaling.
module tb_mem_sram_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // ---------------- DUT 1: ACCESS_CYCLES = 1 ----------------
  logic        rd1 = 0, wr1 = 0;
  logic [31:0] a1 = 0, wd1 = 0;
  logic [31:0] rdat1;
  logic        rdy1;
  wire  [15:0] dq1;
  logic [17:0] sa1;
  logic        we1, oe1, ce1, ub1, lb1;
  logic [15:0] mem1 [0:(1<<18)-1];

  mem_sram_ctrl #(.BASE_ADDR(32'd1024), .SRAM_AW(18), .ACCESS_CYCLES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .rd_en(rd1), .wr_en(wr1), .address(a1),
    .write_data(wd1), .read_data(rdat1), .ready(rdy1), .SRAM_DQ(dq1),
    .SRAM_ADDR(sa1), .SRAM_WE_N(we1), .SRAM_OE_N(oe1), .SRAM_CE_N(ce1),
    .SRAM_UB_N(ub1), .SRAM_LB_N(lb1));

  assign dq1 = (!ce1 && !oe1 && we1) ? mem1[sa1] : 16'bz;
  always @(negedge clk) if (!ce1 && !we1) mem1[sa1] <= dq1;

  // ---------------- DUT 3: ACCESS_CYCLES = 3 ----------------
  logic        rd3 = 0, wr3 = 0;
  logic [31:0] a3 = 0, wd3 = 0;
  logic [31:0] rdat3;
  logic        rdy3;
  wire  [15:0] dq3;
  logic [9:0]  sa3;
  logic        we3, oe3, ce3, ub3, lb3;
  logic [15:0] mem3 [0:1023];

  mem_sram_ctrl #(.BASE_ADDR(32'd1024), .SRAM_AW(10), .ACCESS_CYCLES(3)) u3 (
    .clk(clk), .rst_n(rst_n), .rd_en(rd3), .wr_en(wr3), .address(a3),
    .write_data(wd3), .read_data(rdat3), .ready(rdy3), .SRAM_DQ(dq3),
    .SRAM_ADDR(sa3), .SRAM_WE_N(we3), .SRAM_OE_N(oe3), .SRAM_CE_N(ce3),
    .SRAM_UB_N(ub3), .SRAM_LB_N(lb3));

  assign dq3 = (!ce3 && !oe3 && we3) ? mem3[sa3] : 16'bz;
  always @(negedge clk) if (!ce3 && !we3) mem3[sa3] <= dq3;

  // Bus-sanity monitor on DUT 1: OE and WE never low together, and while
  // reading the bus carries exactly the SRAM's data.
  int bus_viol = 0;
  always @(negedge clk) begin
    if (rst_n && !oe1 && !we1) bus_viol <= bus_viol + 1;
    else if (rst_n && !ce1 && !oe1 && dq1 !== mem1[sa1]) bus_viol <= bus_viol + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Run one request on DUT 1 from a negedge; returns cycles with ready low.
  // Leaves the bench in the DONE cycle with the request dropped.
  task automatic op1(input logic w, input logic r, input logic [31:0] a,
                     input logic [31:0] wd, output int low);
    low = 0;
    wr1 = w; rd1 = r; a1 = a; wd1 = wd;
    #1;
    while (!rdy1 && low < 40) begin
      low++;
      @(negedge clk); #1;
    end
    if (low >= 40) check("op1_timeout", 32'(low), 32'd3);
    wr1 = 0; rd1 = 0;
  endtask

  logic [31:0] refm [0:63];
  logic        refv [0:63];

  initial begin
    int low, oel, alo, ahi, wi;
    logic [31:0] d;
    mem1[1024] = 16'hA5A5; mem1[1025] = 16'hA5A5;
    mem3[10] = 16'h3333;   mem3[11] = 16'h4444;
    for (int i = 0; i < 64; i++) refv[i] = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, rdy1}, 32'd1);
    check("rst_read_data", rdat1, 32'd0);
    check("rst_ctrl", {27'd0, we1, oe1, ce1, ub1, lb1}, 32'h1f);
    check("rst_addr", {14'd0, sa1}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Store then load at 1028 -> halfwords 2/3
    op1(1, 0, 32'd1028, 32'hDEADBEEF, low);
    check("str_low_cycles", 32'(low), 32'd3);
    @(negedge clk); #1;
    check("str_hw2", {16'd0, mem1[2]}, 32'h0000BEEF);
    check("str_hw3", {16'd0, mem1[3]}, 32'h0000DEAD);
    check("idle_ready", {31'd0, rdy1}, 32'd1);
    @(negedge clk);
    op1(0, 1, 32'd1028, 32'h0, low);
    check("ldr_low_cycles", 32'(low), 32'd3);
    check("ldr_data_done", rdat1, 32'hDEADBEEF);
    @(negedge clk); #1;
    check("ldr_data_hold", rdat1, 32'hDEADBEEF);

    // Reset in the middle of a write's HI phase
    @(negedge clk);
    wr1 = 1; a1 = 32'd1040; wd1 = 32'h11112222;
    @(negedge clk);            // LO
    @(negedge clk); #2;        // HI
    check("hi_we_active", {31'd0, we1}, 32'd0);
    rst_n = 1'b0; #1;
    check("abort_we", {31'd0, we1}, 32'd1);
    check("abort_ce", {31'd0, ce1}, 32'd1);
    wr1 = 0;
    @(negedge clk); rst_n = 1'b1; #1;
    check("abort_ready", {31'd0, rdy1}, 32'd1);
    check("abort_read_data", rdat1, 32'd0);

    // Request changes after IDLE exit are ignored
    @(negedge clk);
    wr1 = 1; a1 = 32'd1024; wd1 = 32'hCAFE0001;
    @(negedge clk);
    a1 = 32'd2048; wr1 = 0;
    @(negedge clk); #1;
    check("chg_ready_hi_phase", {31'd0, rdy1}, 32'd0);
    @(negedge clk); #1;
    check("chg_ready_done", {31'd0, rdy1}, 32'd1);
    @(negedge clk);
    check("chg_hw0", {16'd0, mem1[0]}, 32'h0001);
    check("chg_hw1", {16'd0, mem1[1]}, 32'hCAFE);
    check("chg_hw1024", {16'd0, mem1[1024]}, 32'hA5A5);
    check("chg_hw1025", {16'd0, mem1[1025]}, 32'hA5A5);

    // Load something so the simultaneous case has a visible read_data
    op1(0, 1, 32'd1028, 32'h0, low);
    @(negedge clk);
    // rd_en and wr_en together: write wins, read_data untouched
    op1(1, 1, 32'd1032, 32'h12345678, low);
    check("both_low_cycles", 32'(low), 32'd3);
    @(negedge clk); #1;
    check("both_hw4", {16'd0, mem1[4]}, 32'h5678);
    check("both_hw5", {16'd0, mem1[5]}, 32'h1234);
    check("both_read_data", rdat1, 32'hDEADBEEF);

    // Random loads/stores against a reference memory
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      wi = $urandom_range(0, 63);
      if ($urandom_range(0, 1) == 1 || !refv[wi]) begin
        d = $urandom;
        op1(1, 0, 32'd1024 + 32'(wi) * 4, d, low);
        refm[wi] = d; refv[wi] = 1'b1;
      end else begin
        op1(0, 1, 32'd1024 + 32'(wi) * 4, 32'h0, low);
        check("rand_load", rdat1, refm[wi]);
      end
    end
    @(negedge clk);
    check("bus_contention", 32'(bus_viol), 32'd0);

    // Latency scaling with N=3: LDR at word 5 -> halfwords 10/11
    @(negedge clk);
    rd3 = 1; a3 = 32'd1044;
    low = 0; oel = 0; alo = 0; ahi = 0;
    #1;
    while (!rdy3 && low < 40) begin
      low++;
      if (!oe3) begin
        oel++;
        if (sa3 == 10'd10) alo++;
        if (sa3 == 10'd11) ahi++;
      end
      @(negedge clk); #1;
    end
    rd3 = 0;
    check("n3_ready_low", 32'(low), 32'd7);
    check("n3_oe_low", 32'(oel), 32'd6);
    check("n3_addr_lo", 32'(alo), 32'd3);
    check("n3_addr_hi", 32'(ahi), 32'd3);
    check("n3_read_data", rdat3, 32'h44443333);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
